// File: rtl/instr_issue_queue.sv
// instr_issue_queue: FIFO feeding mp_top; issues a NOP (32'd0) every cycle nothing is popped.
// Define INVALID_DROP_EN to discard entries whose opcode mp_top would not execute.
module instr_issue_queue #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH),
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [31:0]      in_instr,
    output logic             in_ready,
    input  logic             issue_en,
    input  logic             flush,
    output logic [31:0]      issue_instr,
    output logic             issue_valid,
    output logic [AW:0]      level,
    output logic [CNT_W-1:0] issued_cnt,
    output logic [CNT_W-1:0] drop_cnt
);
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [31:0]   head;
    logic          push, pop, issue;

    assign head     = mem[rd_ptr];
    assign in_ready = (level != (AW+1)'(DEPTH)) & ~flush;
    assign push     = in_valid & in_ready;
    assign pop      = issue_en & (level != '0) & ~flush;

`ifdef INVALID_DROP_EN
    // Bit n set when opcode n is executed by mp_top: {1..8, 11, 13, 15}
    localparam logic [63:0] VALID_OPS = 64'hA9FE;
    logic drop;
    assign issue = pop & VALID_OPS[head[5:0]];
    assign drop  = pop & ~VALID_OPS[head[5:0]];
    always_ff @(posedge clk or posedge rst)
        if (rst) drop_cnt <= '0;
        else if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
`else
    assign issue    = pop;
    assign drop_cnt = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            level       <= '0;
            issue_instr <= 32'd0;
            issue_valid <= 1'b0;
            issued_cnt  <= '0;
        end else if (flush) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            level       <= '0;
            issue_instr <= 32'd0;
            issue_valid <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            level       <= level + (AW+1)'(push) - (AW+1)'(pop);
            issue_instr <= issue ? head : 32'd0;
            issue_valid <= issue;
            if (issue && issued_cnt != '1) issued_cnt <= issued_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= in_instr;
endmodule

// File: tb/tb_instr_issue_queue.sv
// tb_instr_issue_queue: scoreboard bench; a queue model predicts each issued word and counter state.
module tb_instr_issue_queue;
    logic        clk = 1'b0, rst = 1'b1;
    logic        in_valid = 1'b0, issue_en = 1'b0, flush = 1'b0;
    logic [31:0] in_instr = 32'd0;
    logic        in_ready, issue_valid;
    logic [31:0] issue_instr;
    logic [3:0]  level;
    logic [15:0] issued_cnt, drop_cnt;

    instr_issue_queue dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
        .issue_en(issue_en), .flush(flush), .issue_instr(issue_instr), .issue_valid(issue_valid),
        .level(level), .issued_cnt(issued_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int          n_vec = 0, n_err = 0;
    logic [31:0] m_q[$];
    logic [32:0] sb[$];
    int          m_issued = 0, m_drop = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit op_ok(input logic [31:0] w);
`ifdef INVALID_DROP_EN
        return w[5:0] inside {6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd11, 6'd13, 6'd15};
`else
        return 1'b1;
`endif
    endfunction

    // Drive one cycle, predict its outcome, then compare after the edge.
    task automatic step(input bit v, input logic [31:0] w, input bit en, input bit fl);
        bit rdy, pp;
        logic [31:0] h;
        logic [32:0] e;
        in_valid = v; in_instr = w; issue_en = en; flush = fl;
        #1;
        rdy = (m_q.size() != 8) && !fl;
        chk("in_ready", 32'(in_ready), 32'(rdy));
        pp = en && m_q.size() != 0 && !fl;
        e = 33'd0;
        if (fl) m_q.delete();
        else begin
            if (pp) begin
                h = m_q.pop_front();
                if (op_ok(h)) begin e = {1'b1, h}; if (m_issued < 65535) m_issued++; end
                else if (m_drop < 65535) m_drop++;
            end
            if (v && rdy) m_q.push_back(w);
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("issue_instr", issue_instr, e[31:0]);
        chk("issue_valid", 32'(issue_valid), 32'(e[32]));
        chk("level", 32'(level), 32'(m_q.size()));
        chk("issued_cnt", 32'(issued_cnt), 32'(m_issued));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [31:0] r;
        r = $urandom;
        return r;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        #12 rst = 1'b0;
        chk("rst_instr", issue_instr, 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        // Idle after reset
        repeat (5) step(0, 0, 1, 0);
        // Basic order
        step(1, 32'h00000881, 1, 0);
        step(1, 32'h001F1986, 1, 0);
        step(1, 32'h0000BE0D, 1, 0);
        repeat (2) step(0, 0, 1, 0);
        // Fill while stalled, 9th push refused, then drain
        repeat (8) step(1, rnd_instr(), 0, 0);
        step(1, 32'hDEADBEEF, 0, 0);
        repeat (9) step(0, 0, 1, 0);
        repeat (3) step(1, rnd_instr(), 1, 0);
        repeat (2) step(0, 0, 1, 0);
        // Level held at 4 under simultaneous push/pop
        repeat (4) step(1, rnd_instr(), 0, 0);
        for (int i = 0; i < 6; i++) step(1, 32'h00001000 + 32'(i) * 32'h41 + 32'd1, 1, 0);
        // Flush at level 5 with a push presented
        step(1, rnd_instr(), 0, 0);
        step(1, 32'hCAFE0003, 1, 1);
        repeat (2) step(0, 0, 1, 0);
        // Opcode filter
        step(1, 32'h0000F749, 0, 0);
        step(1, 32'h0000F742, 0, 0);
        repeat (3) step(0, 0, 1, 0);
        // Asynchronous reset mid-stream clears output before the next edge
        step(1, 32'h00000881, 1, 0);
        step(1, 32'h00000882, 1, 0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_instr", issue_instr, 32'd0);
        chk("async_rst_valid", 32'(issue_valid), 32'd0);
        chk("async_rst_level", 32'(level), 32'd0);
        chk("async_rst_cnt", 32'(issued_cnt), 32'd0);
        m_q.delete(); m_issued = 0; m_drop = 0;
        #2 rst = 1'b0;
        step(1, 32'h0003FFC5, 1, 0);
        repeat (2) step(0, 0, 1, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
